rv32_mem_arbiter: RTL and testbench

RV32_MEM_ARBITER -- requirements
Module: rv32_mem_arbiter

---
 rtl/rv32_types.sv | 32 +++
 rtl/rv32_rr_pick2.sv | 26 ++
 rtl/rv32_mem_arbiter.sv | 108 ++++++++++
 tb/tb_rv32_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_types.sv
// Shared RV32 memory-bus types plus the arbiter state encoding and timeout-counter width.
package rv32_types;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef struct packed {
        mem_op_t     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memory_request_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_D = 1'b0,
        PORT_I = 1'b1
    } arb_port_t;

    localparam int ARB_TIMEOUT_W = 10;

    localparam memory_request_t MEM_REQ_IDLE = '{op: MEM_NOP, addr: 32'd0, wdata: 32'd0, wstrb: 4'd0};

endpackage

// File: rtl/rv32_rr_pick2.sv
// Two-way round-robin pick: on a tie the port that did not win last time is chosen.
module rv32_rr_pick2
    import rv32_types::*;
(
    input  logic      valid_d,
    input  logic      valid_i,
    input  arb_port_t last_grant,
    output logic      grant_valid,
    output arb_port_t grant
);

    // NOTE: every output gets a default first so no path through the block can infer a latch.
    always_comb begin
        grant_valid = valid_d | valid_i;
        grant       = PORT_D;
        if (valid_d && valid_i) begin
            if (last_grant == PORT_D)
                grant = PORT_I;
            else
                grant = PORT_D;
        end else if (valid_i) begin
            grant = PORT_I;
        end
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// Shares one memory bus between the data and instruction-fetch ports, with a
// per-transaction timeout that completes the stuck port with zero data and a sticky error.
module rv32_mem_arbiter
    import rv32_types::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            resetn,
    input  memory_request_t d_request,
    output logic            d_done,
    output logic [31:0]     d_rdata,
    input  memory_request_t i_request,
    output logic            i_done,
    output logic [31:0]     i_rdata,
    output memory_request_t mem_request,
    input  logic            mem_done,
    input  logic [31:0]     mem_rdata,
    output logic            bus_error
);

    localparam logic [ARB_TIMEOUT_W-1:0] TIMEOUT_LIMIT = ARB_TIMEOUT_W'(TIMEOUT_CYCLES);

    arb_state_t                state;
    memory_request_t           latch;
    logic [ARB_TIMEOUT_W-1:0]  count;
    arb_port_t                 last_grant;

    logic      grant_valid;
    arb_port_t grant;
    logic      busy;
    logic      owner_live;
    logic      timed_out;
    logic      finish;

    rv32_rr_pick2 u_pick (
        .valid_d     (d_request.op != MEM_NOP),
        .valid_i     (i_request.op != MEM_NOP),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // The count holds the number of busy cycles already spent without mem_done,
    // so the timeout fires in the first busy cycle after TIMEOUT_CYCLES of them.
    assign busy       = (state != IDLE);
    assign timed_out  = busy && !mem_done && (count == TIMEOUT_LIMIT);
    assign finish     = busy && (mem_done || timed_out);
    assign owner_live = ((state == BUSY_D) && (d_request.op != MEM_NOP)) ||
                        ((state == BUSY_I) && (i_request.op != MEM_NOP));

    // The latch is cleared whenever the FSM is idle, so it drives the bus directly.
    assign mem_request = latch;

    always_comb begin
        d_done  = 1'b0;
        d_rdata = 32'd0;
        i_done  = 1'b0;
        i_rdata = 32'd0;
        // A completion during reset belongs to an abandoned transaction.
        if (resetn && finish && owner_live) begin
            if (state == BUSY_D) begin
                d_done  = 1'b1;
                d_rdata = mem_done ? mem_rdata : 32'd0;
            end else begin
                i_done  = 1'b1;
                i_rdata = mem_done ? mem_rdata : 32'd0;
            end
        end
    end

    // NOTE: all state updates are non-blocking so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            latch      <= MEM_REQ_IDLE;
            count      <= '0;
            last_grant <= PORT_I;
            bus_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        latch      <= (grant == PORT_D) ? d_request : i_request;
                        state      <= (grant == PORT_D) ? BUSY_D : BUSY_I;
                        last_grant <= grant;
                        count      <= '0;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (finish) begin
                        state <= IDLE;
                        latch <= MEM_REQ_IDLE;
                        if (timed_out)
                            bus_error <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    latch <= MEM_REQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rv32_mem_arbiter;
    import rv32_types::*;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            resetn;
    memory_request_t d_request, i_request, mem_request;
    logic            d_done, i_done, mem_done, bus_error;
    logic [31:0]     d_rdata, i_rdata, mem_rdata;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .d_request   (d_request),
        .d_done      (d_done),
        .d_rdata     (d_rdata),
        .i_request   (i_request),
        .i_done      (i_done),
        .i_rdata     (i_rdata),
        .mem_request (mem_request),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .bus_error   (bus_error)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding bus transaction, its owner, its age in busy cycles.
    bit              m_busy  = 1'b0;
    int              m_owner = 0;
    memory_request_t m_req   = '0;
    int              m_age   = 0;
    int              m_last  = 1;
    bit              m_err   = 1'b0;

    bit [1:0]        e_done;
    logic [31:0]     e_rdata [2];
    memory_request_t e_memreq;

    logic [1:0]      s_done;
    logic [31:0]     s_rdata [2];
    memory_request_t s_memreq;
    logic            s_err;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic memory_request_t mk(input mem_op_t op, input logic [31:0] a, input logic [31:0] w);
        mk = '{op: op, addr: a, wdata: w, wstrb: 4'hf};
    endfunction

    // Called right after a rising edge with inputs already set; returns just after the next one.
    task automatic tick();
        memory_request_t req [2];
        bit fin, fin_to, dv, iv;
        @(negedge clk);
        req[0]   = d_request;
        req[1]   = i_request;
        e_done   = 2'b00;
        e_rdata[0] = 32'd0;
        e_rdata[1] = 32'd0;
        e_memreq = m_busy ? m_req : '0;
        fin      = 1'b0;
        fin_to   = 1'b0;
        if (resetn && m_busy) begin
            fin_to = !mem_done && (m_age >= TO);
            fin    = mem_done || fin_to;
            if (fin && req[m_owner].op != MEM_NOP) begin
                e_done[m_owner]  = 1'b1;
                e_rdata[m_owner] = mem_done ? mem_rdata : 32'd0;
            end
        end

        s_done     = {i_done, d_done};
        s_rdata[0] = d_rdata;
        s_rdata[1] = i_rdata;
        s_memreq   = mem_request;
        s_err      = bus_error;
        check("mem_request", s_memreq, e_memreq);
        check("d_done", s_done[0], e_done[0]);
        check("d_rdata", s_rdata[0], e_rdata[0]);
        check("i_done", s_done[1], e_done[1]);
        check("i_rdata", s_rdata[1], e_rdata[1]);
        check("bus_error", s_err, m_err);

        if (!resetn) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_last = 1;
            m_err  = 1'b0;
        end else if (m_busy) begin
            if (fin) begin
                m_busy = 1'b0;
                if (fin_to) m_err = 1'b1;
            end else begin
                m_age++;
            end
        end else begin
            dv = (req[0].op != MEM_NOP);
            iv = (req[1].op != MEM_NOP);
            if (dv || iv) begin
                m_owner = (dv && iv) ? (1 - m_last) : (dv ? 0 : 1);
                m_req   = req[m_owner];
                m_busy  = 1'b1;
                m_age   = 0;
                m_last  = m_owner;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]      seq_d, seq_i;
        memory_request_t st, r;

        resetn    = 1'b0;
        d_request = '0;
        i_request = '0;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mem_done = 1'b1;
        tick();
        check("reset_d_done", s_done[0], 1'b0);
        check("reset_memop", s_memreq.op, MEM_NOP);

        // Both ports requesting from reset: data, fetch, data, fetch with an idle cycle between.
        resetn    = 1'b1;
        d_request = mk(MEM_LOAD, 32'h40, 32'd0);
        i_request = mk(MEM_LOAD, 32'h80, 32'd0);
        mem_done  = 1'b1;
        mem_rdata = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            tick();
            seq_d[k] = s_done[0];
            seq_i[k] = s_done[1];
        end
        check("rr_order_d", seq_d, 8'b0010_0010);
        check("rr_order_i", seq_i, 8'b1000_1000);
        d_request = '0;
        i_request = '0;
        mem_done  = 1'b0;
        repeat (2) tick();

        // Single load, memory answers on the third bus cycle.
        d_request = mk(MEM_LOAD, 32'h100, 32'd0);
        tick();
        check("load_n_memop", s_memreq.op, MEM_NOP);
        tick();
        check("load_n1_memreq", s_memreq, mk(MEM_LOAD, 32'h100, 32'd0));
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        check("load_n3_d_done", s_done[0], 1'b1);
        check("load_n3_d_rdata", s_rdata[0], 32'hDEAD_BEEF);
        check("load_n3_i_done", s_done[1], 1'b0);
        d_request = '0;
        mem_done  = 1'b0;
        tick();
        check("load_n4_memop", s_memreq.op, MEM_NOP);

        // Store aborted by the requester after one cycle still finishes on the bus.
        st        = mk(MEM_STORE, 32'h200, 32'hCAFE_0001);
        d_request = st;
        tick();
        tick();
        check("abort_n1_memreq", s_memreq, st);
        d_request = '0;
        tick();
        check("abort_n2_memreq", s_memreq, st);
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h5555_5555;
        tick();
        check("abort_n4_memreq", s_memreq, st);
        check("abort_n4_d_done", s_done[0], 1'b0);
        mem_done = 1'b0;
        tick();
        check("abort_n5_memop", s_memreq.op, MEM_NOP);

        // mem_done lands exactly in the timeout cycle: normal completion, no error.
        d_request = mk(MEM_LOAD, 32'h300, 32'd0);
        tick();
        repeat (4) tick();
        mem_done  = 1'b1;
        mem_rdata = 32'hA5A5_5A5A;
        tick();
        check("tie_d_done", s_done[0], 1'b1);
        check("tie_d_rdata", s_rdata[0], 32'hA5A5_5A5A);
        d_request = '0;
        mem_done  = 1'b0;
        tick();
        check("tie_bus_error", s_err, 1'b0);

        // Fetch that never completes times out after four silent busy cycles.
        i_request = mk(MEM_LOAD, 32'h400, 32'd0);
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        seq_i = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seq_i[k] = s_done[1];
        end
        check("to_early_i_done", seq_i, 8'h00);
        tick();
        check("to_i_done", s_done[1], 1'b1);
        check("to_i_rdata", s_rdata[1], 32'd0);
        i_request = '0;
        tick();
        check("to_bus_error", s_err, 1'b1);
        check("to_memop", s_memreq.op, MEM_NOP);
        tick();
        check("to_bus_error_held", s_err, 1'b1);

        // Reset in the middle of a data transaction; late mem_done is ignored.
        d_request = mk(MEM_LOAD, 32'h500, 32'd0);
        tick();
        tick();
        resetn    = 1'b0;
        d_request = '0;
        tick();
        resetn = 1'b1;
        tick();
        mem_done  = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        check("rst_d_done", s_done[0], 1'b0);
        check("rst_memop", s_memreq.op, MEM_NOP);
        check("rst_bus_error", s_err, 1'b0);
        mem_done = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                r = (p == 0) ? d_request : i_request;
                if (e_done[p]) begin
                    r = '0;
                end else if (r.op != MEM_NOP) begin
                    if ($urandom_range(0, 24) == 0)
                        r = '0;
                    else if ($urandom_range(0, 9) == 0)
                        r.addr = $urandom;
                end else if (!(m_busy && m_owner == p) && $urandom_range(0, 1) == 1) begin
                    r = mk(($urandom_range(0, 1) == 1) ? MEM_LOAD : MEM_STORE, $urandom, $urandom);
                end
                if (p == 0) d_request = r;
                else        i_request = r;
            end
            mem_done  = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            resetn    = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
